// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC link arbiter: FSM state encodings and a
// width helper used to size index and counter fields.
package cdc_arb_pkg;

  // Link arbiter FSM states (encodings are fixed: IDLE=0, SETUP=1, HOLD=2)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

  // Ceiling log2 with a floor of 1, so a field is never zero bits wide
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// valid bit found when searching upward from last+1, wrapping modulo N.
module rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant
);

  logic found;

  // Scan N positions starting just after the previous winner
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && valid[(int'(last) + k) % N]) begin
        grant[(int'(last) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_link_arbiter.sv
// Round-robin arbiter feeding one toggle-handshake synchronizer link.
// An accepted word is registered onto link_word, link_toggle flips one cycle
// later, and the word is then held for at least HOLD cycles so the
// destination domain can sample it safely.
// Build option: define CDC_LINK_ARB_ACK_EN to add the link_ack input; the
// hold phase then also waits until the destination's echo matches the toggle.
module cdc_link_arbiter
  import cdc_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int HOLD  = 4,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic                  clkA,
  input  logic                  rstA,
`ifdef CDC_LINK_ARB_ACK_EN
  input  logic                  link_ack,
`endif
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      link_word,
  output logic [IDW-1:0]        link_id,
  output logic                  link_toggle,
  output logic                  busy
);

  localparam int CW = clog2(HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  arb_state_t       stateReg, stateNext;
  logic [CW-1:0]    cntReg;
  logic [IDW-1:0]   lastGrantReg;
  logic [WIDTH-1:0] linkWordReg;
  logic [IDW-1:0]   linkIdReg;
  logic             toggleReg;

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  readyInt;
  logic [IDW-1:0]   grantIdx;
  logic             accept;
  logic             holdDone;
  logic [WIDTH-1:0] reqWord [NREQ];

  // Unpack the flat request bus into one word per requester
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign reqWord[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_rr (
    .valid (req_valid),
    .last  (lastGrantReg),
    .grant (grant)
  );

  // One-hot grant to binary index of the winning requester
  always_comb begin
    grantIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) grantIdx = IDW'(k);
    end
  end

`ifdef CDC_LINK_ARB_ACK_EN
  assign holdDone = (cntReg == HOLD_LAST) && (link_ack == toggleReg);
`else
  assign holdDone = (cntReg == HOLD_LAST);
`endif

  assign accept = |readyInt;

  // Next-state logic; grants are offered only while idle and out of reset
  always_comb begin
    stateNext = stateReg;
    readyInt  = '0;
    unique case (stateReg)
      ST_IDLE: begin
        if (!rstA) readyInt = grant;
        if (accept) stateNext = ST_SETUP;
      end
      ST_SETUP: stateNext = ST_HOLD;
      ST_HOLD:  if (holdDone) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // State, hold counter, link registers and round-robin pointer
  always_ff @(posedge clkA) begin
    if (rstA) begin
      stateReg     <= ST_IDLE;
      cntReg       <= '0;
      lastGrantReg <= IDW'(NREQ - 1);
      linkWordReg  <= '0;
      linkIdReg    <= '0;
      toggleReg    <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        linkWordReg  <= reqWord[grantIdx];
        linkIdReg    <= grantIdx;
        lastGrantReg <= grantIdx;
      end
      if (stateReg == ST_SETUP) begin
        // Word has been stable for one cycle; announce it now
        toggleReg <= ~toggleReg;
        cntReg    <= '0;
      end else if (stateReg == ST_HOLD && cntReg != HOLD_LAST) begin
        // Saturates at HOLD-1 so a late acknowledge never wraps the count
        cntReg <= cntReg + CW'(1);
      end
    end
  end

  assign req_ready   = readyInt;
  assign link_word   = rstA ? '0 : linkWordReg;
  assign link_id     = rstA ? '0 : linkIdReg;
  assign link_toggle = rstA ? 1'b0 : toggleReg;
  assign busy        = !rstA && (stateReg != ST_IDLE);

endmodule

// File: tb/tb_cdc_link_arbiter.sv
// Self-checking bench for cdc_link_arbiter (WIDTH=8, NREQ=4, HOLD=4).
// A cycle-level reference model tracks busy time, the round-robin pointer,
// the launched word and the pending toggle from the timing rules.
module tb_cdc_link_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int HOLD  = 4;

  logic        clkA = 1'b0;
  logic        rstA;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  link_word;
  logic [1:0]  link_id;
  logic        link_toggle;
  logic        busy;

  int nChecks = 0;
  int nFail   = 0;

  // Model state
  int   mBusy, mLast, mPend, mId;
  logic [7:0] mWord;
  logic       mTog;
  // Expected outputs for the current cycle
  logic [3:0] eReady;
  logic [7:0] eWord;
  logic [1:0] eId;
  logic       eTog, eBusy;
  int         lastPick;

  initial forever #5 clkA = ~clkA;

`ifdef CDC_LINK_ARB_ACK_EN
  logic        link_ack;
  logic [15:0] ackHist = '0;
  int          ackDelay = 0;
  always @(posedge clkA) ackHist <= {ackHist[14:0], link_toggle};
  always_comb begin
    link_ack = link_toggle;
    if (ackDelay > 0) link_ack = ackHist[ackDelay-1];
  end
`endif

  cdc_link_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .HOLD(HOLD)) dut (
    .clkA        (clkA),
    .rstA        (rstA),
`ifdef CDC_LINK_ARB_ACK_EN
    .link_ack    (link_ack),
`endif
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .link_word   (link_word),
    .link_id     (link_id),
    .link_toggle (link_toggle),
    .busy        (busy)
  );

  // Drive one cycle of inputs, derive expected outputs, advance the model
  task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic r);
    int pick;
    @(negedge clkA);
    req_valid = v;
    req_data  = d;
    rstA      = r;
    #1;
    pick = -1;
    if (!r && mBusy == 0)
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && v[(mLast + k) % 4]) pick = (mLast + k) % 4;
    eReady   = (pick >= 0) ? (4'b0001 << pick) : 4'b0000;
    eBusy    = r ? 1'b0 : (mBusy > 0);
    eWord    = r ? 8'h00 : mWord;
    eId      = r ? 2'd0 : 2'(mId);
    eTog     = r ? 1'b0 : mTog;
    lastPick = pick;
    if (|req_ready)
      $display("t=%0t grant ready=%b word=%h", $time, req_ready, req_data[31:0]);
    if (r) begin
      mBusy = 0; mLast = 3; mPend = 0; mWord = 8'h00; mId = 0; mTog = 1'b0;
    end else begin
      if (mBusy > 0) mBusy--;
      if (mPend > 0) begin
        mPend--;
        if (mPend == 0) mTog = ~mTog;
      end
      if (pick >= 0) begin
        mBusy = HOLD + 1;
        mPend = 1;
        mLast = pick;
        mWord = d[pick*8 +: 8];
        mId   = pick;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, $urandom, 1'b1);
      nChecks++;
      if ({req_ready, link_word, link_id, link_toggle, busy} !== 16'h0) begin
        nFail++;
        $display("FAIL reset cycle %0d: got ready=%b word=%h id=%0d tog=%b busy=%b, want all zero",
                 i, req_ready, link_word, link_id, link_toggle, busy);
      end
    end
  endtask

  task automatic test_single();
    cyc(4'b0100, 32'h00A5_0000, 1'b0);
    nChecks++;
    if (req_ready !== 4'b0100) begin
      nFail++;
      $display("FAIL single ready: got %b want 0100", req_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(4'b0000, 32'h0, 1'b0);
      nChecks++;
      if ({req_ready, link_word, link_id, link_toggle, busy} !== {eReady, eWord, eId, eTog, eBusy}) begin
        nFail++;
        $display("FAIL single model t+%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", k,
                 req_ready, link_word, link_id, link_toggle, busy, eReady, eWord, eId, eTog, eBusy);
      end
      nChecks++;
      if ((k == 1 && {link_word, link_id, link_toggle} !== {8'hA5, 2'd2, 1'b0}) ||
          (k == 2 && link_toggle !== 1'b1) ||
          (k == 5 && busy !== 1'b1) ||
          (k == 6 && busy !== 1'b0)) begin
        nFail++;
        $display("FAIL single timing t+%0d: got word=%h id=%0d tog=%b busy=%b", k,
                 link_word, link_id, link_toggle, busy);
      end
    end
  endtask

  task automatic test_saturation();
    int gIdx[$];
    int gCyc[$];
    cyc(4'hF, 32'h0, 1'b1);
    for (int c = 0; c < 26; c++) begin
      cyc(4'hF, $urandom, 1'b0);
      nChecks++;
      if ({req_ready, link_word, link_id, link_toggle, busy} !== {eReady, eWord, eId, eTog, eBusy}) begin
        nFail++;
        $display("FAIL saturation cycle %0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", c,
                 req_ready, link_word, link_id, link_toggle, busy, eReady, eWord, eId, eTog, eBusy);
      end
      if (|req_ready) begin
        nChecks++;
        if (link_toggle !== 1'(gIdx.size() % 2)) begin
          nFail++;
          $display("FAIL saturation toggle at grant %0d: got %b want %0d",
                   gIdx.size(), link_toggle, gIdx.size() % 2);
        end
        for (int k = 0; k < 4; k++) if (req_ready[k]) gIdx.push_back(k);
        gCyc.push_back(c);
      end
    end
    nChecks++;
    if (gIdx.size() != 5) begin
      nFail++;
      $display("FAIL saturation grant count: got %0d want 5", gIdx.size());
    end else begin
      for (int n = 0; n < 5; n++) begin
        nChecks++;
        if (gIdx[n] != n % 4 || gCyc[n] != 6 * n) begin
          nFail++;
          $display("FAIL saturation grant %0d: got req %0d at cycle %0d want req %0d at cycle %0d",
                   n, gIdx[n], gCyc[n], n % 4, 6 * n);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int gIdx[$];
    int want[3] = '{3, 1, 3};
    cyc(4'h0, 32'h0, 1'b1);
    cyc(4'b0010, $urandom, 1'b0);
    nChecks++;
    if (req_ready !== 4'b0010) begin
      nFail++;
      $display("FAIL fairness setup grant: got %b want 0010", req_ready);
    end
    for (int c = 1; c < 20; c++) begin
      cyc(4'b1010, $urandom, 1'b0);
      for (int k = 0; k < 4; k++) if (req_ready[k]) gIdx.push_back(k);
    end
    nChecks++;
    if (gIdx.size() != 3) begin
      nFail++;
      $display("FAIL fairness grant count: got %0d want 3", gIdx.size());
    end else begin
      for (int n = 0; n < 3; n++) begin
        nChecks++;
        if (gIdx[n] != want[n]) begin
          nFail++;
          $display("FAIL fairness grant %0d: got req %0d want req %0d", n, gIdx[n], want[n]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(4'h0, 32'h0, 1'b1);
    cyc(4'b0001, 32'h0000_005A, 1'b0);
    cyc(4'h0, 32'h0, 1'b0);
    cyc(4'h0, 32'h0, 1'b0);
    nChecks++;
    if ({link_word, link_toggle, busy} !== {8'h5A, 1'b1, 1'b1}) begin
      nFail++;
      $display("FAIL resetmid pre: got word=%h tog=%b busy=%b want 5a/1/1", link_word, link_toggle, busy);
    end
    for (int k = 3; k <= 4; k++) begin
      cyc(4'h0, 32'h0, (k == 3));
      nChecks++;
      if ({req_ready, link_word, link_id, link_toggle, busy} !== 16'h0) begin
        nFail++;
        $display("FAIL resetmid t+%0d: got %b/%h/%0d/%b/%b want all zero", k,
                 req_ready, link_word, link_id, link_toggle, busy);
      end
    end
    cyc(4'hF, 32'h1122_3344, 1'b0);
    nChecks++;
    if (req_ready !== 4'b0001) begin
      nFail++;
      $display("FAIL resetmid resume: got ready=%b want 0001", req_ready);
    end
  endtask

  task automatic test_random();
    logic r;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 63) == 0);
      cyc(4'($urandom), $urandom, r);
      nChecks++;
      if ({req_ready, link_word, link_id, link_toggle, busy} !== {eReady, eWord, eId, eTog, eBusy}) begin
        nFail++;
        $display("FAIL random cycle %0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", c,
                 req_ready, link_word, link_id, link_toggle, busy, eReady, eWord, eId, eTog, eBusy);
      end
    end
  endtask

`ifdef CDC_LINK_ARB_ACK_EN
  task automatic test_ack();
    ackDelay = 10;
    for (int i = 0; i < 12; i++) cyc(4'h0, 32'h0, 1'b1);
    cyc(4'b0001, 32'h0000_0077, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      cyc(4'hF, $urandom, 1'b0);
      nChecks++;
      if (k <= 12 && (busy !== 1'b1 || req_ready !== 4'b0000)) begin
        nFail++;
        $display("FAIL ack wait t+%0d: got busy=%b ready=%b want 1/0000", k, busy, req_ready);
      end else if (k == 13 && (busy !== 1'b0 || req_ready !== 4'b0010)) begin
        nFail++;
        $display("FAIL ack release t+13: got busy=%b ready=%b want 0/0010", busy, req_ready);
      end
    end
    ackDelay = 0;
  endtask
`endif

  initial begin
    rstA = 1'b1; req_valid = '0; req_data = '0;
    mBusy = 0; mLast = 3; mPend = 0; mWord = 8'h00; mId = 0; mTog = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef CDC_LINK_ARB_ACK_EN
    test_ack();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cdc_link_arbiter.md
CDC_LINK_ARBITER -- requirements
Module: cdc_link_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload word width in bits.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, range 2..16.
REQ-003 SHALL have parameter HOLD, default 4: minimum number of cycles link_word stays stable after each toggle, range 2..255.
REQ-004 SHALL have localparam IDW = clog2(NREQ), minimum 1.
REQ-005 SHALL have one clock and a synchronous active-high reset; every other port is synchronous to clkA.
  - clkA  in  1  clock; all state updates on its rising edge.
  - rstA  in  1  synchronous reset, active-high.
REQ-006 SHALL have the following ports:
  - req_valid  in  NREQ  requester i has a word pending.
  - req_data  in  NREQ*WIDTH  word of requester i, in bits [i*WIDTH +: WIDTH].
  - req_ready  out  NREQ  one-hot grant; requester i's word is accepted when valid[i] and ready[i] are both high.
  - link_word  out  WIDTH  registered payload driven onto the shared synchronizer link.
  - link_id  out  IDW  registered index of the requester that owns link_word.
  - link_toggle  out  1  flips once per launched word; the destination detects a new word from the flip.
  - busy  out  1  high whenever the state is not IDLE.

Function
REQ-007 SHALL implement a three-state FSM.
  - IDLE -> SETUP: on acceptance.
  - SETUP -> HOLD: always, after 1 cycle.
  - HOLD -> IDLE: when the hold counter reaches HOLD-1.
REQ-008 In IDLE, req_ready SHALL be the combinational one-hot round-robin pick among req_valid bits; it SHALL be all zeros in SETUP and HOLD, or when no request is valid.
REQ-009 Round-robin search SHALL start at last_grant+1 modulo NREQ; last_grant SHALL update on each acceptance.
REQ-010 On acceptance at cycle t: link_word/link_id SHALL update at t+1; link_toggle SHALL invert at t+2; state SHALL be HOLD for t+2..t+HOLD+1 and IDLE at t+HOLD+2.
  - Result: link_word is stable 1 cycle before and at least HOLD cycles after every toggle edge.
REQ-011 link_word and link_id SHALL change only on the cycle after an acceptance.
REQ-012 Minimum spacing between acceptances SHALL be HOLD+2 cycles.
REQ-013 A requester deasserting req_valid before it is granted SHALL simply not be selected; no state change results.
REQ-014 The hold counter SHALL be ceil(log2(HOLD)) bits wide and SHALL NOT wrap within a HOLD phase.

Reset
REQ-015 While rstA is high, every output SHALL be driven to zero (req_ready, link_word, link_id, link_toggle, busy).
REQ-016 Reset SHALL set the state to IDLE, the counter to 0 and last_grant to NREQ-1, so requester 0 wins first.
REQ-017 Reset mid-SETUP or mid-HOLD SHALL abort the transfer.
  - The accepted word is dropped and no toggle occurs.
  - Outputs are zero on the cycle after rstA is sampled high.

Configuration
REQ-018 With macro CDC_LINK_ARB_ACK_EN defined:
  - A port link_ack (in, 1) SHALL exist; it is the destination's toggle echo, already synchronized into clkA.
  - HOLD->IDLE SHALL additionally require link_ack == link_toggle.
REQ-019 Without CDC_LINK_ARB_ACK_EN, the link_ack port SHALL be absent and HOLD SHALL end purely on the counter.

Structure
REQ-020 SHALL define the FSM state encodings (IDLE=0, SETUP=1, HOLD=2) and the clog2 function in a shared package, cdc_arb_pkg.
REQ-021 SHALL place round-robin selection in a sub-module, rr_arbiter (inputs: valid, last; output: one-hot grant), reusable elsewhere.

Verification
Bench settings: WIDTH=8, NREQ=4, HOLD=4.
REQ-022 Reset: hold rstA for 3 cycles with all req_valid high -> req_ready=0, link_word=0x00, link_toggle=0, busy=0 throughout.
REQ-023 Single request: req_valid[2]=1, data 0xA5 at t.
  - req_ready=4'b0100 at t.
  - link_word=0xA5 and link_id=2 at t+1.
  - link_toggle 0->1 at t+2.
  - busy=0 at t+6.
REQ-024 Saturation: all four requesters valid continuously -> grants in order 0,1,2,3,0, exactly 6 cycles apart, with link_toggle alternating.
REQ-025 Fairness: requesters 1 and 3 valid, last grant 1 -> grant order 3,1,3.
REQ-026 Reset at t+3 of a transfer -> all outputs zero at t+4, no toggle, and IDLE grant to requester 0 resumes after rstA falls.
REQ-027 ACK_EN build: link_ack lags the toggle by 10 cycles -> busy stays high until link_ack matches, and no grant occurs earlier.
